// File: rtl/handshake_mem_q.sv
// Valid/ready request port onto a MEM_DEPTH x DATA_WD word array, with read data
// (and optional write acks) returned in order through an RSP_DEPTH-entry response FIFO.
module handshake_mem_q #(
  parameter int DATA_WD    = 4,
  parameter int ADDR_WD    = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int RSP_DEPTH  = 2,
  parameter int RSP_WR_ACK = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           valid_in,
  input  logic                           cmd_in,
  input  logic [ADDR_WD-1:0]             addr_in,
  input  logic [DATA_WD-1:0]             data_in,
  output logic                           ready_in,
  output logic                           valid_out,
  output logic                           cmd_out,
  output logic [DATA_WD-1:0]             data_out,
  output logic                           err_out,
  input  logic                           ready_out,
  output logic [$clog2(RSP_DEPTH+1)-1:0] rsp_count
);

  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_WD:0]  MEM_LIMIT = (ADDR_WD + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
  localparam logic              WR_ACK    = (RSP_WR_ACK != 0);

  // Handshake: a request transfers on the rising edge where valid_in & ready_in,
  // a response on the edge where valid_out & ready_out; the producer holds valid
  // and its fields stable until that edge.

  logic [DATA_WD-1:0] mem [MEM_DEPTH];

  logic [DATA_WD-1:0] rsp_data_q [RSP_DEPTH];
  logic               rsp_cmd_q  [RSP_DEPTH];
  logic               rsp_err_q  [RSP_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               fire_in;
  logic               fire_out;
  logic               push;
  logic               range_err;
  logic [MEM_AW-1:0]  mem_idx;
  logic [DATA_WD-1:0] push_data;

  // A full FIFO still accepts when the head is leaving this cycle.
  assign ready_in  = (count_q < CNT_FULL) | ready_out;
  assign fire_in   = valid_in & ready_in;
  assign valid_out = (count_q != '0);
  assign fire_out  = valid_out & ready_out;

  assign range_err = ({1'b0, addr_in} >= MEM_LIMIT);
  assign mem_idx   = addr_in[MEM_AW-1:0];
  assign push      = fire_in & (~cmd_in | WR_ACK);
  assign push_data = (cmd_in | range_err) ? '0 : mem[mem_idx];

  always_ff @(posedge clk) begin
    if (fire_in & cmd_in & ~range_err) begin
      mem[mem_idx] <= data_in;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (fire_out) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, fire_out})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rsp_data_q[i] <= '0;
        rsp_cmd_q[i]  <= 1'b0;
        rsp_err_q[i]  <= 1'b0;
      end
    end else if (push) begin
      rsp_data_q[wr_ptr_q] <= push_data;
      rsp_cmd_q[wr_ptr_q]  <= cmd_in;
      rsp_err_q[wr_ptr_q]  <= range_err;
    end
  end

  assign cmd_out   = rsp_cmd_q[rd_ptr_q];
  assign data_out  = rsp_data_q[rd_ptr_q];
  assign err_out   = rsp_err_q[rd_ptr_q];
  assign rsp_count = count_q;

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    push |-> ((count_q < CNT_FULL) || fire_out));

  a_rsp_stable : assert property (@(posedge clk) disable iff (!rstn)
    (valid_out && !ready_out) |=> (valid_out && $stable({cmd_out, err_out, data_out})));
`endif

endmodule

// File: tb/tb_handshake_mem_q.sv
// Bench for handshake_mem_q: instance A (16 words, 2-entry FIFO, silent writes) and
// instance B (12 words, 3-entry FIFO, write acks), checked against a memory model and per-instance response queues.
module tb_handshake_mem_q;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int EW = DW + 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_in  [2];
  logic          cmd_in    [2];
  logic [AW-1:0] addr_in   [2];
  logic [DW-1:0] data_in   [2];
  logic          ready_out [2];
  logic          ready_in  [2];
  logic          valid_out [2];
  logic          cmd_out   [2];
  logic          err_out   [2];
  logic [DW-1:0] data_out  [2];
  logic [1:0]    rsp_count [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Expected responses, entry = {cmd, err, data}
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [DW-1:0] mem_m [2][16];

  always #5 clk = ~clk;

  handshake_mem_q #(.DATA_WD(DW), .ADDR_WD(AW), .MEM_DEPTH(16), .RSP_DEPTH(2), .RSP_WR_ACK(0)) u_dut_a (
    .clk(clk), .rstn(rstn),
    .valid_in(valid_in[0]), .cmd_in(cmd_in[0]), .addr_in(addr_in[0]), .data_in(data_in[0]),
    .ready_in(ready_in[0]), .valid_out(valid_out[0]), .cmd_out(cmd_out[0]),
    .data_out(data_out[0]), .err_out(err_out[0]), .ready_out(ready_out[0]),
    .rsp_count(rsp_count[0])
  );

  handshake_mem_q #(.DATA_WD(DW), .ADDR_WD(AW), .MEM_DEPTH(12), .RSP_DEPTH(3), .RSP_WR_ACK(1)) u_dut_b (
    .clk(clk), .rstn(rstn),
    .valid_in(valid_in[1]), .cmd_in(cmd_in[1]), .addr_in(addr_in[1]), .data_in(data_in[1]),
    .ready_in(ready_in[1]), .valid_out(valid_out[1]), .cmd_out(cmd_out[1]),
    .data_out(data_out[1]), .err_out(err_out[1]), .ready_out(ready_out[1]),
    .rsp_count(rsp_count[1])
  );

  function automatic int mem_depth(int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic int rsp_depth(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic bit wr_ack(int d);
    return (d == 1);
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [EW-1:0] qfront(int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic void qpush(int d, logic [EW-1:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic void qpop(int d);
    if (d == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: sampled mid-cycle, so pops/pushes decided here happen at the next rising edge.
  always @(negedge clk) begin
    int            sz;
    bit            rdy;
    bit            oor;
    string         nm;
    logic [EW-1:0] head;
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "A" : "B";
      if (!rstn) begin
        if (d == 0) exp_q0.delete();
        else        exp_q1.delete();
      end else begin
        sz  = qsize(d);
        rdy = (sz < rsp_depth(d)) || (ready_out[d] === 1'b1);
        check({nm, " rsp_count"}, 32'(rsp_count[d]), 32'(sz));
        check({nm, " valid_out"}, 32'(valid_out[d]), 32'(sz != 0));
        check({nm, " ready_in"},  32'(ready_in[d]),  32'(rdy));
        if (sz != 0) begin
          head = qfront(d);
          check({nm, " rsp_head"}, 32'({cmd_out[d], err_out[d], data_out[d]}), 32'(head));
          if (ready_out[d]) qpop(d);
        end
        if (valid_in[d] && rdy) begin
          oor = (int'(addr_in[d]) >= mem_depth(d));
          if (cmd_in[d]) begin
            if (!oor) mem_m[d][addr_in[d]] = data_in[d];
            if (wr_ack(d)) qpush(d, {1'b1, oor, {DW{1'b0}}});
          end else begin
            qpush(d, {1'b0, oor, oor ? {DW{1'b0}} : mem_m[d][addr_in[d]]});
          end
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; leaves valid_in high for back-to-back use.
  task automatic send(int d, bit c, int a, int dat);
    bit acc;
    int budget;
    valid_in[d] = 1'b1;
    cmd_in[d]   = c;
    addr_in[d]  = AW'(a);
    data_in[d]  = DW'(dat);
    acc    = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      acc = ready_in[d];
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) check("accept timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(int d);
    valid_in[d] = 1'b0;
  endtask

  task automatic drain(int d);
    int budget;
    ready_out[d] = 1'b1;
    budget = 0;
    while (qsize(d) != 0 && budget < 50) begin
      cycles(1);
      budget++;
    end
    check("drain", 32'(qsize(d)), 32'd0);
  endtask

  task automatic rand_run(int d, int n);
    for (int i = 0; i < n; i++) begin
      send(d, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        idle(d);
        cycles($urandom_range(1, 2));
      end
    end
    idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid_in[d]  = 1'b0;
      cmd_in[d]    = 1'b0;
      addr_in[d]   = '0;
      data_in[d]   = '0;
      ready_out[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      check("reset valid_out", 32'(valid_out[d]), 32'd0);
      check("reset rsp_count", 32'(rsp_count[d]), 32'd0);
      check("reset data_out",  32'(data_out[d]),  32'd0);
      check("reset cmd_err",   32'({cmd_out[d], err_out[d]}), 32'd0);
    end
    rstn = 1'b1;
    cycles(1);

    // Preload every address (B's 12..15 are out of range and must be dropped).
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) send(d, 1'b1, a, $urandom_range(0, 15));
      idle(d);
    end
    cycles(4);

    // Write then read back with the consumer ready.
    send(0, 1'b1, 3, 5);
    send(0, 1'b0, 3, 0);
    idle(0);
    cycles(3);

    // Back-pressure: third read waits until the first response pops.
    send(0, 1'b1, 1, 'hA);
    send(0, 1'b1, 2, 'hB);
    send(0, 1'b1, 3, 'hC);
    idle(0);
    cycles(1);
    ready_out[0] = 1'b0;
    send(0, 1'b0, 1, 0);
    send(0, 1'b0, 2, 0);
    check("full rsp_count", 32'(rsp_count[0]), 32'd2);
    check("full ready_in",  32'(ready_in[0]),  32'd0);
    fork
      send(0, 1'b0, 3, 0);
      begin
        cycles(3);
        ready_out[0] = 1'b1;
      end
    join
    idle(0);
    cycles(4);

    // Streaming reads at full rate across pointer wrap.
    for (int i = 0; i < 8; i++) send(0, 1'b0, i, 0);
    idle(0);
    cycles(3);

    // Out-of-range write/read and neighbour check on the 12-word instance.
    send(1, 1'b1, 13, 7);
    send(1, 1'b0, 13, 0);
    send(1, 1'b0, 11, 0);
    idle(1);
    cycles(3);

    // Write ack followed immediately by read-after-write.
    send(1, 1'b1, 0, 9);
    send(1, 1'b0, 0, 0);
    idle(1);
    cycles(4);

    // Reset with both FIFOs holding entries; memory must survive it.
    ready_out[0] = 1'b0;
    ready_out[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < rsp_depth(d); i++) send(d, 1'b0, 4 + i, 0);
      idle(d);
    end
    cycles(1);
    check("pre-reset A count", 32'(rsp_count[0]), 32'd2);
    check("pre-reset B count", 32'(rsp_count[1]), 32'd3);
    #1;
    rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("async rst valid_out", 32'(valid_out[d]), 32'd0);
      check("async rst rsp_count", 32'(rsp_count[d]), 32'd0);
      check("async rst data_out",  32'(data_out[d]),  32'd0);
    end
    @(posedge clk);
    #2;
    rstn = 1'b1;
    cycles(1);
    ready_out[0] = 1'b1;
    ready_out[1] = 1'b1;
    send(0, 1'b0, 3, 0);
    idle(0);
    send(1, 1'b0, 0, 0);
    idle(1);
    cycles(3);

    // Random traffic with a randomly stalling consumer on both instances.
    fork
      rand_run(0, 120);
      rand_run(1, 120);
      begin
        repeat (600) begin
          @(posedge clk);
          #1;
          ready_out[0] = 1'($urandom_range(0, 1));
          ready_out[1] = 1'($urandom_range(0, 1));
        end
        ready_out[0] = 1'b1;
        ready_out[1] = 1'b1;
      end
    join

    drain(0);
    drain(1);
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_mem_q.md
Name: handshake_mem_q

Overview:
- Parametrised successor to the single-slot valid/ready register-file block.
- Requests (read/write) arrive on a valid/ready channel and access an internal MEM_DEPTH x DATA_WD array.
- Read responses, and optionally write acks, are queued in an RSP_DEPTH-entry response FIFO, so back-to-back reads pipeline at full rate while the response consumer stalls.
- Out-of-range addresses are flagged as errors instead of aliasing.

Parameters:
- DATA_WD, 4, data width in bits.
- ADDR_WD, 4, request address width.
- MEM_DEPTH, 16, number of implemented words. Legal range 1..2^ADDR_WD.
- RSP_DEPTH, 2, response FIFO entries. Must be >=1; need not be a power of two.
- RSP_WR_ACK, 0, 1 = every accepted write also pushes a response; 0 = writes are silent.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- valid_in  input  1  request valid.
- cmd_in  input  1  1 = write, 0 = read.
- addr_in  input  ADDR_WD  word address.
- data_in  input  DATA_WD  write data.
- ready_in  output  1  request ready.
- valid_out  output  1  response valid.
- cmd_out  output  1  response type: 1 = write ack, 0 = read data.
- data_out  output  DATA_WD  read data; 0 for write acks and errors.
- err_out  output  1  1 = address >= MEM_DEPTH.
- ready_out  input  1  response ready.
- rsp_count  output  $clog2(RSP_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock domain, clk. rstn is asynchronous, active-low.
- Reset values:
  - valid_out = 0, cmd_out = 0, data_out = 0, err_out = 0, rsp_count = 0.
  - FIFO pointers = 0; all FIFO entries cleared to 0.
  - Memory contents are not reset and are undefined until written.
- Handshake definitions:
  - fire_in = valid_in & ready_in.
  - fire_out = valid_out & ready_out.
  - Each request transfers exactly once per fire_in.
- ready_in = (rsp_count < RSP_DEPTH) | ready_out.
  - ready_in is independent of cmd_in and valid_in.
  - The ready_out -> ready_in combinational path is intentional.
- push = fire_in & (~cmd_in | RSP_WR_ACK).
- valid_out = (rsp_count != 0). The response fields are driven directly from the FIFO head entry, with no extra output register.
- Write (fire_in & cmd_in):
  - Address < MEM_DEPTH: mem[addr_in] <= data_in at the accepting edge.
  - Address out of range: memory is unchanged.
  - If RSP_WR_ACK=1, push {cmd=1, data=0, err=range_err}.
- Read (fire_in & ~cmd_in):
  - Address < MEM_DEPTH: push {cmd=0, data=mem[addr_in], err=0} at the accepting edge.
  - Address out of range: push {cmd=0, data=0, err=1}.
- Latency: a response is visible on valid_out one cycle after fire_in when the FIFO was empty or popping.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- FIFO occupancy:
  - push & ~fire_out: count +1.
  - fire_out & ~push: count -1.
  - push & fire_out: count unchanged, both pointers advance.
  - This must hold when full (RSP_DEPTH entries) and when holding exactly one entry.
- Pointer wrap: wr_ptr and rd_ptr wrap from RSP_DEPTH-1 to 0.
- Ordering: responses leave strictly in request order.
- Overflow: push never occurs when count == RSP_DEPTH and ~fire_out; this is guaranteed by ready_in.
- Valid stability: once valid_out=1, valid_out and the head fields stay stable until fire_out.
- ready_out with empty FIFO: ignored.
- Input protocol: valid_in may be deasserted without transfer. addr_in, cmd_in and data_in are only sampled on fire_in.
- Reset mid-operation: the FIFO empties immediately (async). No response is emitted for requests accepted before reset. Memory retains its prior contents.

Test Plan:
1. Reset, then write 0x5 to addr 3; read addr 3 with ready_out=1 -> valid_out=1 one cycle after read fire_in, data_out=0x5, cmd_out=0, err_out=0, rsp_count=1 then 0.
2. ready_out=0, RSP_DEPTH=2, three consecutive reads of addrs 1,2,3 (preloaded 0xA,0xB,0xC) -> ready_in drops after the 2nd accept, rsp_count=2; raise ready_out -> third read accepted in the same cycle as the first pop; outputs 0xA,0xB,0xC in order.
3. Continuous streaming of 8 reads with ready_out=1 -> ready_in stays 1, one response per cycle, rsp_count stays 1; pointer wrap is exercised with no loss or duplication.
4. MEM_DEPTH=12, write 0x7 to addr 13, then read addr 13 -> err_out=1, data_out=0; read addr 12-1=11 is unaffected by the write; with RSP_WR_ACK=1 the write also yields cmd_out=1, err_out=1.
5. RSP_WR_ACK=1, write 0x9 to addr 0 then immediately read addr 0 -> two responses in order: {cmd=1, data=0, err=0}, then {cmd=0, data=0x9, err=0}.
6. Fill FIFO to 2 entries with ready_out=0, assert rstn=0 mid-cycle -> valid_out, rsp_count, data_out go to 0 immediately; after release, reading an earlier-written address returns the pre-reset value.
